// File: rtl/obi_sram_bridge.sv
// -----------------------------------------------------------------------------
// eros_obi_pkg / obi_sram_bridge
//
// Purpose:
//   Adapts the OBI slave port of the N-to-1 crossbar to a single-port SRAM
//   macro whose read latency is fixed at elaboration time. At most one
//   transaction is in flight. Every granted request gets exactly one rvalid.
//   A new request can be granted on the same cycle that returns rvalid, so a
//   Latency=1 SRAM sustains one access per cycle.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous reset, active-low
//   obi_req_i    in   {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   obi_resp_o   out  {gnt, rvalid, rdata[31:0]}
//   sram_req_o   out  SRAM chip enable, one cycle per access
//   sram_we_o    out  SRAM write enable     (pass-through of obi_req_i.we)
//   sram_be_o    out  SRAM byte enables     (pass-through of obi_req_i.be)
//   sram_addr_o  out  SRAM word address     (obi_req_i.addr[AddrWidth+1:2])
//   sram_wdata_o out  SRAM write data       (pass-through of obi_req_i.wdata)
//   sram_rdata_i in   SRAM read data, valid Latency cycles after sram_req_o
//   dbg_state_o  out  FSM state for observation: 0 = IDLE, 1 = BUSY
//
// Handshake semantics:
//   gnt is only ever asserted while req is high; the cycle with req & gnt is
//   the accept cycle. Exactly Latency cycles later rvalid is high for one
//   cycle. Upstream may withdraw req without having seen gnt. There is never
//   more than one accepted request without its rvalid.
// -----------------------------------------------------------------------------

package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_sram_bridge #(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned Latency  = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  eros_obi_pkg::obi_req_t         obi_req_i,
    output eros_obi_pkg::obi_resp_t        obi_resp_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [3:0]                     sram_be_o,
    output logic [$clog2(NumWords)-1:0]    sram_addr_o,
    output logic [31:0]                    sram_wdata_o,
    input  logic [31:0]                    sram_rdata_i,
    output logic                           dbg_state_o
);

    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned CntW      = (Latency > 1) ? $clog2(Latency) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_we;
    logic [31:0]       r_rdata;

    state_e            w_state_d;
    logic [CntW-1:0]   w_cnt_d;
    logic              w_we_d;
    logic              w_gnt;
    logic              w_rvalid;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    // Upper and byte-offset address bits are dropped on purpose: the SRAM
    // aliases every NumWords*4 bytes.
    assign w_unused_addr = ^{obi_req_i.addr[31:AddrWidth+2], obi_req_i.addr[1:0]};

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_we_d    = r_we;
        w_gnt     = 1'b0;
        w_rvalid  = 1'b0;
        w_rdata   = r_rdata;

        case (r_state)
            IDLE: begin
                // Gate with rst_ni so nothing is granted while held in reset.
                w_gnt = obi_req_i.req & rst_ni;
                if (w_gnt) begin
                    w_state_d = BUSY;
                    w_cnt_d   = CntW'(Latency - 1);
                    w_we_d    = obi_req_i.we;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CntW'(1);
                end else begin
                    // Response cycle: return data and accept the next request.
                    w_rvalid = 1'b1;
                    w_rdata  = r_we ? 32'h0 : sram_rdata_i;
                    w_gnt    = obi_req_i.req & rst_ni;
                    if (w_gnt) begin
                        w_cnt_d = CntW'(Latency - 1);
                        w_we_d  = obi_req_i.we;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_we    <= w_we_d;
            if (w_rvalid) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign obi_resp_o.gnt    = w_gnt;
    assign obi_resp_o.rvalid = w_rvalid;
    assign obi_resp_o.rdata  = w_rdata;

    assign sram_req_o   = w_gnt;
    assign sram_we_o    = obi_req_i.we;
    assign sram_be_o    = obi_req_i.be;
    assign sram_addr_o  = obi_req_i.addr[AddrWidth+1:2];
    assign sram_wdata_o = obi_req_i.wdata;

    assign dbg_state_o  = r_state;

    if (Latency < 1 || Latency > 4) begin : g_bad_latency
        $error("obi_sram_bridge: Latency must be in 1..4");
    end

    if (NumWords < 2 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_depth
        $error("obi_sram_bridge: NumWords must be a power of two >= 2");
    end

`ifndef SYNTHESIS
    a_rvalid_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_rvalid |-> (r_state == BUSY));
    a_gnt_needs_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_gnt |-> obi_req_i.req);
`endif

endmodule

// File: tb/tb_obi_sram_bridge.sv
module tb_obi_sram_bridge;
    import eros_obi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni;

    obi_req_t  req;
    obi_resp_t resp1, resp2, resp3;

    logic        s1_req, s1_we, s2_req, s2_we, s3_req, s3_we;
    logic [3:0]  s1_be, s2_be, s3_be;
    logic [9:0]  s1_addr, s2_addr, s3_addr;
    logic [31:0] s1_wdata, s2_wdata, s3_wdata;
    logic [31:0] s1_rdata, s2_rdata, s3_rdata;
    logic        dbg1, dbg2, dbg3;

    logic [31:0] mem [1024];
    logic [31:0] p1 [1];
    logic [31:0] p2 [2];
    logic [31:0] p3 [3];

    int n_checks;
    int n_fail;

    obi_sram_bridge #(.NumWords(1024), .Latency(1)) u_l1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .obi_req_i(req), .obi_resp_o(resp1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_be_o(s1_be), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wdata), .sram_rdata_i(s1_rdata), .dbg_state_o(dbg1)
    );
    obi_sram_bridge #(.NumWords(1024), .Latency(2)) u_l2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .obi_req_i(req), .obi_resp_o(resp2),
        .sram_req_o(s2_req), .sram_we_o(s2_we), .sram_be_o(s2_be), .sram_addr_o(s2_addr),
        .sram_wdata_o(s2_wdata), .sram_rdata_i(s2_rdata), .dbg_state_o(dbg2)
    );
    obi_sram_bridge #(.NumWords(1024), .Latency(3)) u_l3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .obi_req_i(req), .obi_resp_o(resp3),
        .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_be_o(s3_be), .sram_addr_o(s3_addr),
        .sram_wdata_o(s3_wdata), .sram_rdata_i(s3_rdata), .dbg_state_o(dbg3)
    );

    // SRAM models: read data of the addressed word appears Latency cycles later.
    always_ff @(posedge clk_i) begin
        p1[0] <= mem[s1_addr];
        p2[0] <= mem[s2_addr];
        p2[1] <= p2[0];
        p3[0] <= mem[s3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign s1_rdata = p1[0];
    assign s2_rdata = p2[1];
    assign s3_rdata = p3[2];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req.req   = 1'b1;
        req.we    = we;
        req.be    = be;
        req.addr  = addr;
        req.wdata = wdata;
    endtask

    task automatic idle_req();
        req = '0;
    endtask

    task automatic do_reset();
        idle_req();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5555_0000 | i;
        mem[1] = 32'hCAFE_0001;
        mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'h0000_0011;

        // Reset state
        rst_ni = 1'b0;
        idle_req();
        repeat (2) @(posedge clk_i);
        #1;
        settle();
        check("rst_gnt", resp1.gnt, 0);
        check("rst_rvalid", resp1.rvalid, 0);
        check("rst_rdata", resp1.rdata, 0);
        check("rst_sram_req", s1_req, 0);
        check("rst_state", dbg1, 0);
        check("rst_rvalid_l3", resp3.rvalid, 0);
        drive(1'b0, 4'hF, 32'h10, 32'h0);
        settle();
        check("rst_gnt_req_held", resp1.gnt, 0);
        idle_req();
        rst_ni = 1'b1;

        // L1 read addr 0x10 -> word 4
        next_cycle();
        drive(1'b0, 4'hF, 32'h10, 32'h0);
        settle();
        check("l1_rd_gnt", resp1.gnt, 1);
        check("l1_rd_sram_req", s1_req, 1);
        check("l1_rd_addr", 32'(s1_addr), 4);
        next_cycle();
        idle_req();
        settle();
        check("l1_rd_rvalid", resp1.rvalid, 1);
        check("l1_rd_rdata", resp1.rdata, 32'hDEAD_BEEF);
        check("l1_rd_gnt_off", resp1.gnt, 0);
        next_cycle();
        settle();
        check("l1_rd_rvalid_drop", resp1.rvalid, 0);
        check("l1_rd_hold", resp1.rdata, 32'hDEAD_BEEF);
        check("l1_rd_state_idle", dbg1, 0);

        // L1 write be=3 addr 0x8
        next_cycle();
        drive(1'b1, 4'b0011, 32'h8, 32'hA5A5_1234);
        settle();
        check("l1_wr_gnt", resp1.gnt, 1);
        check("l1_wr_we", s1_we, 1);
        check("l1_wr_be", 32'(s1_be), 3);
        check("l1_wr_addr", 32'(s1_addr), 2);
        check("l1_wr_wdata", s1_wdata, 32'hA5A5_1234);
        next_cycle();
        idle_req();
        settle();
        check("l1_wr_rvalid", resp1.rvalid, 1);
        check("l1_wr_rdata", resp1.rdata, 0);

        // L1 alias read 0x1004 -> word 1
        next_cycle();
        drive(1'b0, 4'hF, 32'h0000_1004, 32'h0);
        settle();
        check("alias_addr", 32'(s1_addr), 1);
        next_cycle();
        idle_req();
        settle();
        check("alias_rdata", resp1.rdata, 32'hCAFE_0001);

        // L1 back-to-back: grant on the rvalid cycle
        next_cycle();
        drive(1'b0, 4'hF, 32'h10, 32'h0);
        settle();
        check("b2b_gnt0", resp1.gnt, 1);
        next_cycle();
        drive(1'b0, 4'hF, 32'h14, 32'h0);
        settle();
        check("b2b_rvalid1", resp1.rvalid, 1);
        check("b2b_rdata1", resp1.rdata, 32'hDEAD_BEEF);
        check("b2b_gnt1", resp1.gnt, 1);
        next_cycle();
        idle_req();
        settle();
        check("b2b_rvalid2", resp1.rvalid, 1);
        check("b2b_rdata2", resp1.rdata, 32'h0000_0011);

        // rdata hold over idle cycles, then write returns 0
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            settle();
            check("hold_rvalid", resp1.rvalid, 0);
            check("hold_rdata", resp1.rdata, 32'h0000_0011);
        end
        next_cycle();
        drive(1'b1, 4'hF, 32'h20, 32'h1234_5678);
        settle();
        next_cycle();
        idle_req();
        settle();
        check("hold_wr_rvalid", resp1.rvalid, 1);
        check("hold_wr_rdata", resp1.rdata, 0);
        next_cycle();
        settle();
        check("hold_wr_after", resp1.rdata, 0);

        // L3 back-to-back reads held on req
        do_reset();
        next_cycle();
        drive(1'b0, 4'hF, 32'h10, 32'h0);
        settle();
        check("l3_gnt_t0", resp3.gnt, 1);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            settle();
            check("l3_gnt", resp3.gnt, (k == 3) ? 1 : 0);
            check("l3_sram_req", s3_req, (k == 3) ? 1 : 0);
            check("l3_rvalid", resp3.rvalid, (k == 3) ? 1 : 0);
            if (k == 3) check("l3_rdata_t3", resp3.rdata, 32'hDEAD_BEEF);
        end
        next_cycle();
        idle_req();
        settle();
        check("l3_rvalid_t6", resp3.rvalid, 1);
        check("l3_rdata_t6", resp3.rdata, 32'hDEAD_BEEF);
        check("l3_gnt_t6", resp3.gnt, 0);
        next_cycle();
        settle();
        check("l3_idle_t7", dbg3, 0);

        // L2 reset mid-transaction
        do_reset();
        next_cycle();
        drive(1'b0, 4'hF, 32'h10, 32'h0);
        settle();
        check("l2_rst_gnt_t0", resp2.gnt, 1);
        check("l2_rst_busy_pre", dbg2, 0);
        next_cycle();
        idle_req();
        rst_ni = 1'b0;
        settle();
        check("l2_rst_rvalid_t1", resp2.rvalid, 0);
        check("l2_rst_state_t1", dbg2, 0);
        check("l2_rst_gnt_t1", resp2.gnt, 0);
        check("l2_rst_sram_req_t1", s2_req, 0);
        check("l2_rst_rdata_t1", resp2.rdata, 0);
        rst_ni = 1'b1;
        next_cycle();
        settle();
        check("l2_rst_rvalid_t2", resp2.rvalid, 0);
        check("l2_rst_state_t2", dbg2, 0);
        check("l2_rst_rdata_t2", resp2.rdata, 0);

        // L2 normal read
        next_cycle();
        drive(1'b0, 4'hF, 32'h14, 32'h0);
        settle();
        check("l2_gnt", resp2.gnt, 1);
        next_cycle();
        idle_req();
        settle();
        check("l2_rvalid_t1", resp2.rvalid, 0);
        check("l2_busy_t1", dbg2, 1);
        next_cycle();
        settle();
        check("l2_rvalid_t2", resp2.rvalid, 1);
        check("l2_rdata_t2", resp2.rdata, 32'h0000_0011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
